// File: rtl/dp_memory_if.sv
// Bus bundle for dp_memory: read/write port A, read-only port B and the clear/busy pair.
interface dp_memory_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int LANE_SIZE = 8
);
    localparam int LANES = WORD_SIZE / LANE_SIZE;

    logic                 a_req;
    logic                 a_we;
    logic [LANES-1:0]     a_be;
    logic [ADDR_SIZE-1:0] a_addr;
    logic [WORD_SIZE-1:0] a_wdata;
    logic [WORD_SIZE-1:0] a_rdata;
    logic                 a_rvalid;
    logic                 b_req;
    logic [ADDR_SIZE-1:0] b_addr;
    logic [WORD_SIZE-1:0] b_rdata;
    logic                 b_rvalid;
    logic                 clear;
    logic                 busy;

    modport master (
        output a_req, a_we, a_be, a_addr, a_wdata, b_req, b_addr, clear,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, busy
    );

    modport slave (
        input  a_req, a_we, a_be, a_addr, a_wdata, b_req, b_addr, clear,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, busy
    );
endinterface

// File: rtl/dp_memory.sv
// Dual-port word memory with lane-masked writes on port A, read port B, and a
// full-array zero sweep run after reset and on request.
module dp_memory #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int LANE_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst,
    dp_memory_if.slave    bus
);
    localparam int LANES = WORD_SIZE / LANE_SIZE;
    localparam int DEPTH = 1 << ADDR_SIZE;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state_q;
    logic [ADDR_SIZE-1:0] clr_ptr_q;
    logic [ADDR_SIZE-1:0] clr_ptr_d;
    logic                 busy_q;
    logic                 a_rvalid_q;
    logic                 b_rvalid_q;
    logic [WORD_SIZE-1:0] a_rdata_q;
    logic [WORD_SIZE-1:0] b_rdata_q;
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    logic accept;
    logic a_wr;
    logic a_rd;
    logic b_rd;
    logic clr_wr;

    // A clear request in IDLE takes priority over any access sampled on the same edge.
    assign accept    = (state_q == IDLE) && !bus.clear;
    assign a_wr      = accept && bus.a_req && bus.a_we;
    assign a_rd      = accept && bus.a_req && !bus.a_we;
    assign b_rd      = accept && bus.b_req;
    assign clr_wr    = (state_q == CLEAR) && !rst;
    assign clr_ptr_d = clr_ptr_q + 1'b1;

    // The array itself has no reset; zeroing happens only through the sweep.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.a_be[i]) begin
                    mem_q[bus.a_addr][i*LANE_SIZE +: LANE_SIZE] <= bus.a_wdata[i*LANE_SIZE +: LANE_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            // Reads sample the array before this edge's write lands (read-before-write).
            if (a_rd) a_rdata_q <= mem_q[bus.a_addr];
            if (b_rd) b_rdata_q <= mem_q[bus.b_addr];

            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == '1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_d;
                    end
                end
                IDLE: begin
                    if (bus.clear) begin
                        clr_ptr_q <= '0;
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_dp_memory.sv
// Bench for dp_memory: vector table for the access rules, model-driven scoreboard
// for clear sweeps and reset abort.
module tb_dp_memory;
    localparam int W = 16;
    localparam int A = 4;
    localparam int L = 8;
    localparam int D = 16;

    logic clk;
    logic rst;

    dp_memory_if #(.WORD_SIZE(W), .ADDR_SIZE(A), .LANE_SIZE(L)) bus ();

    dp_memory #(.WORD_SIZE(W), .ADDR_SIZE(A), .LANE_SIZE(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        a_req;
        logic        a_we;
        logic [1:0]  a_be;
        logic [3:0]  a_addr;
        logic [15:0] a_wdata;
        logic        b_req;
        logic [3:0]  b_addr;
        logic        clear;
    } stim_t;

    typedef struct {
        logic        a_v;
        logic [15:0] a_d;
        logic        b_v;
        logic [15:0] b_d;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic [15:0] mm [D];
    int          busy_cnt;
    logic [15:0] last_a;
    logic [15:0] last_b;
    exp_t        sbq [$];
    int          n_vec;
    int          n_miss;
    vec_t        tbl [13];
    exp_t        none;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic ar, input logic aw, input logic [1:0] be,
                                 input logic [3:0] aa, input logic [15:0] wd,
                                 input logic br, input logic [3:0] ba, input logic cl);
        stim_t s;
        s.a_req = ar; s.a_we = aw; s.a_be = be; s.a_addr = aa; s.a_wdata = wd;
        s.b_req = br; s.b_addr = ba; s.clear = cl;
        return s;
    endfunction

    function automatic vec_t row(input logic ar, input logic aw, input logic [1:0] be,
                                 input logic [3:0] aa, input logic [15:0] wd,
                                 input logic br, input logic [3:0] ba,
                                 input logic eav, input logic [15:0] ead,
                                 input logic ebv, input logic [15:0] ebd);
        vec_t v;
        v.s = mk(ar, aw, be, aa, wd, br, ba, 1'b0);
        v.e.a_v = eav; v.e.a_d = ead; v.e.b_v = ebv; v.e.b_d = ebd;
        return v;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < D; i++) mm[i] = 16'h0000;
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard: got empty queue required one entry");
        end else begin
            e = sbq.pop_front();
            chk("a_rvalid", 32'(bus.a_rvalid), 32'(e.a_v));
            chk("a_rdata",  32'(bus.a_rdata),  32'(e.a_d));
            chk("b_rvalid", 32'(bus.b_rvalid), 32'(e.b_v));
            chk("b_rdata",  32'(bus.b_rdata),  32'(e.b_d));
        end
        chk("busy", 32'(bus.busy), (busy_cnt > 0) ? 32'd1 : 32'd0);
    endtask

    // Drives one cycle, predicts the outputs after the edge, then checks them.
    task automatic cycle(input stim_t s, input bit use_tbl, input exp_t te);
        exp_t pe;
        logic acc;
        bus.a_req = s.a_req; bus.a_we = s.a_we; bus.a_be = s.a_be; bus.a_addr = s.a_addr;
        bus.a_wdata = s.a_wdata; bus.b_req = s.b_req; bus.b_addr = s.b_addr; bus.clear = s.clear;
        acc = (busy_cnt == 0) && !s.clear;
        pe.a_v = acc && s.a_req && !s.a_we;
        pe.a_d = pe.a_v ? mm[s.a_addr] : last_a;
        pe.b_v = acc && s.b_req;
        pe.b_d = pe.b_v ? mm[s.b_addr] : last_b;
        if (acc && s.a_req && s.a_we) begin
            if (s.a_be[0]) mm[s.a_addr][7:0]  = s.a_wdata[7:0];
            if (s.a_be[1]) mm[s.a_addr][15:8] = s.a_wdata[15:8];
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
        end else if (s.clear) begin
            busy_cnt = D;
            model_zero();
        end
        last_a = pe.a_d;
        last_b = pe.b_d;
        sbq.push_back(use_tbl ? te : pe);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic wait_sweep(input string nm, input stim_t s);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            n++;
            cycle(s, 1'b0, none);
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        none = '{1'b0, 16'h0, 1'b0, 16'h0};

        tbl[0]  = row(1, 0, 2'b00, 5,  16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000);
        tbl[1]  = row(1, 1, 2'b11, 3,  16'hBEEF, 0, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[2]  = row(1, 1, 2'b01, 3,  16'h1234, 0, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[3]  = row(1, 0, 2'b00, 3,  16'h0000, 0, 0, 1, 16'hBE34, 0, 16'h0000);
        tbl[4]  = row(1, 1, 2'b11, 7,  16'h1111, 0, 0, 0, 16'hBE34, 0, 16'h0000);
        tbl[5]  = row(1, 1, 2'b11, 7,  16'hAAAA, 1, 7, 0, 16'hBE34, 1, 16'h1111);
        tbl[6]  = row(0, 0, 2'b00, 0,  16'h0000, 1, 7, 0, 16'hBE34, 1, 16'hAAAA);
        tbl[7]  = row(1, 0, 2'b00, 7,  16'h0000, 1, 3, 1, 16'hAAAA, 1, 16'hBE34);
        tbl[8]  = row(1, 1, 2'b10, 3,  16'h9900, 1, 3, 0, 16'hAAAA, 1, 16'hBE34);
        tbl[9]  = row(1, 0, 2'b00, 3,  16'h0000, 0, 0, 1, 16'h9934, 0, 16'hBE34);
        tbl[10] = row(1, 1, 2'b00, 3,  16'hFFFF, 1, 3, 0, 16'h9934, 1, 16'h9934);
        tbl[11] = row(1, 1, 2'b11, 15, 16'hF00D, 0, 0, 0, 16'h9934, 0, 16'h9934);
        tbl[12] = row(1, 0, 2'b00, 15, 16'h0000, 1, 0, 1, 16'hF00D, 1, 16'h0000);

        // Reset state and the initial sweep
        rst = 1'b1;
        bus.a_req = 0; bus.a_we = 0; bus.a_be = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_addr = 0; bus.clear = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",     32'(bus.busy),     32'd1);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("rst_a_rdata",  32'(bus.a_rdata),  32'd0);
        chk("rst_b_rdata",  32'(bus.b_rdata),  32'd0);
        rst = 1'b0;
        busy_cnt = D;
        last_a = 16'h0;
        last_b = 16'h0;
        model_zero();
        wait_sweep("busy_after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 13; i++) cycle(tbl[i].s, 1'b1, tbl[i].e);

        // Clear pulse with a colliding write, accesses during the sweep, then full readback
        cycle(mk(1, 1, 2'b11, 2, 16'h5555, 1, 2, 1), 1'b0, none);
        wait_sweep("busy_after_clear", mk(1, 1, 2'b11, 4, 16'h7777, 1, 4, 0));
        for (int i = 0; i < D; i++) cycle(mk(1, 0, 0, 4'(i), 0, 1, 4'(15 - i), 0), 1'b0, none);

        // Reset in the middle of a sweep
        cycle(mk(1, 1, 2'b11, 1, 16'hCAFE, 0, 0, 0), 1'b0, none);
        cycle(mk(1, 0, 2'b00, 1, 16'h0000, 1, 1, 0), 1'b0, none);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b0, none);
        repeat (9) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, none);
        rst = 1'b1;
        #1;
        chk("abort_busy",     32'(bus.busy),     32'd1);
        chk("abort_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("abort_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("abort_a_rdata",  32'(bus.a_rdata),  32'd0);
        chk("abort_b_rdata",  32'(bus.b_rdata),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_cnt = D;
        last_a = 16'h0;
        last_b = 16'h0;
        model_zero();
        wait_sweep("busy_after_abort", mk(1, 0, 0, 5, 0, 1, 6, 0));
        cycle(mk(1, 1, 2'b11, 12, 16'h4321, 1, 9, 0), 1'b0, none);
        cycle(mk(1, 0, 2'b00, 12, 16'h0000, 1, 12, 0), 1'b0, none);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, none);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dp_memory.md
DP_MEMORY -- requirements
Module: dp_memory

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 8: address width in bits; depth = 2^ADDR_SIZE words.
REQ-003 SHALL have parameter LANE_SIZE, default 8: write-enable lane width in bits; WORD_SIZE SHALL be an integer multiple of LANE_SIZE; LANES = WORD_SIZE/LANE_SIZE.
REQ-004 SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port a_req  input  1  port A access request.
REQ-007 SHALL have port a_we  input  1  port A write (1) / read (0).
REQ-008 SHALL have port a_be  input  LANES  port A per-lane write enable.
REQ-009 SHALL have port a_addr  input  ADDR_SIZE  port A address.
REQ-010 SHALL have port a_wdata  input  WORD_SIZE  port A write data.
REQ-011 SHALL have port a_rdata  output  WORD_SIZE  port A read data, registered.
REQ-012 SHALL have port a_rvalid  output  1  a_rdata valid, one-cycle pulse.
REQ-013 SHALL have port b_req  input  1  port B read request.
REQ-014 SHALL have port b_addr  input  ADDR_SIZE  port B address.
REQ-015 SHALL have port b_rdata  output  WORD_SIZE  port B read data, registered.
REQ-016 SHALL have port b_rvalid  output  1  b_rdata valid, one-cycle pulse.
REQ-017 SHALL have port clear  input  1  request a full zero sweep of the array.
REQ-018 SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-019 SHALL implement an FSM with states CLEAR and IDLE; busy = (state == CLEAR), driven from a register.
REQ-020 In CLEAR, each cycle SHALL write 0 to mem[clr_ptr] and increment clr_ptr; on the edge where clr_ptr == 2^ADDR_SIZE-1, SHALL go to IDLE; a sweep takes exactly 2^ADDR_SIZE cycles.
REQ-021 In IDLE, clear=1 sampled on an edge SHALL reset clr_ptr to 0 and go to CLEAR; busy rises after that edge.
REQ-022 clear SHALL be ignored while in CLEAR; the sweep SHALL NOT restart.
REQ-023 While busy=1, or in any cycle where clear=1 is sampled in IDLE, a_req and b_req SHALL be ignored: no array write, no rvalid.
REQ-024 Accepted port A write (a_req=1, a_we=1): for each lane i with a_be[i]=1, mem[a_addr] lane i SHALL take a_wdata lane i; lanes with a_be[i]=0 SHALL keep their value; a_rvalid stays 0.
REQ-025 Accepted port A read (a_req=1, a_we=0): a_rdata SHALL = mem[a_addr] and a_rvalid SHALL = 1 in the cycle after the request (latency 1).
REQ-026 Accepted port B read: b_rdata SHALL = mem[b_addr] and b_rvalid SHALL = 1 in the cycle after the request (latency 1).
REQ-027 Port B read and port A write to the same address in the same cycle SHALL return the pre-write contents on b_rdata (read-before-write).
REQ-028 a_rdata and b_rdata SHALL hold their last value when the matching rvalid is 0.
REQ-029 Both ports SHALL accept a new request every cycle with no back-pressure when busy=0.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_SIZE; clr_ptr SHALL be ADDR_SIZE bits wide and stop at the last address.

Reset
REQ-031 rst=1 SHALL immediately force state=CLEAR, clr_ptr=0, busy=1, a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0.
REQ-032 Array contents SHALL NOT be cleared asynchronously; zeroing SHALL come only from the CLEAR sweep that starts on the first edge after rst falls.
REQ-033 rst asserted mid-sweep or mid-access SHALL abort it; after rst falls a full sweep SHALL restart from address 0.

Verification (WORD_SIZE=16, ADDR_SIZE=4, LANE_SIZE=8)
REQ-034 Reset release -> busy=1 for exactly 16 cycles then 0; A read at 5 -> a_rdata=0x0000, a_rvalid pulse next cycle.
REQ-035 A write 0xBEEF at 3, a_be=11; A write 0x1234 at 3, a_be=01; A read at 3 -> 0xBE34.
REQ-036 mem[7]=0x1111; same cycle A write 0xAAAA at 7 and B read at 7 -> b_rdata=0x1111; next B read at 7 -> 0xAAAA.
REQ-037 One-cycle clear pulse in IDLE, with a_req write 0x5555 at 2 in the same cycle -> write dropped, busy high 16 cycles, a_req/b_req during busy give no rvalid; afterwards all addresses read 0x0000.
REQ-038 rst asserted when clr_ptr=9 -> outputs at reset values immediately; after release busy=1 for 16 more cycles.
